// File: rtl/fpu_issue_ctrl.sv
// Command issuer for the fpu: queues {funct,a,b}, starts the fpu, waits for finish, returns results.
// Optional build macro FPU_ISSUE_STATS_EN adds saturating issue/timeout statistics outputs.
module fpu_issue_ctrl #(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_funct,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [1:0]  fpu_funct,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_start,
    input  logic [31:0] fpu_o,
    input  logic        fpu_finish,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_o,
    output logic [1:0]  res_funct,
    output logic        res_err
`ifdef FPU_ISSUE_STATS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_timeouts
`endif
);

    localparam int          AW   = $clog2(CMD_DEPTH);
    localparam int          TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t        state, state_nxt;
    logic [65:0]   fifo_mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic          finish_q, finish_edge, timeout_hit;
    logic [TW-1:0] tmo_cnt;

    // Readiness comes from the registered count only, so a full FIFO never accepts even while popping.
    assign cmd_ready   = (count != (AW+1)'(CMD_DEPTH));
    assign push        = cmd_valid & cmd_ready;
    assign finish_edge = fpu_finish & ~finish_q;
    assign timeout_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        fpu_start = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fpu_start = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (finish_edge || timeout_hit) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_funct, cmd_a, cmd_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Operand registers stay loaded through WAIT; the result is latched once when WAIT ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpu_funct <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            res_o     <= '0;
            res_funct <= '0;
            res_err   <= 1'b0;
            tmo_cnt   <= '0;
            finish_q  <= 1'b0;
        end else begin
            finish_q <= fpu_finish;
            if (pop) {fpu_funct, fpu_a, fpu_b} <= fifo_mem[rd_ptr];
            if (state == ST_ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == ST_WAIT) begin
                if (finish_edge) begin
                    res_o     <= fpu_o;
                    res_funct <= fpu_funct;
                    res_err   <= 1'b0;
                end else if (timeout_hit) begin
                    res_o     <= QNAN;
                    res_funct <= fpu_funct;
                    res_err   <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

`ifdef FPU_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued   <= '0;
            stat_timeouts <= '0;
        end else begin
            if (state == ST_ISSUE && stat_issued != 16'hFFFF)
                stat_issued <= stat_issued + 16'd1;
            if (state == ST_WAIT && !finish_edge && timeout_hit && stat_timeouts != 16'hFFFF)
                stat_timeouts <= stat_timeouts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with a small behavioural fpu model.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_funct = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [1:0]  fpu_funct;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_start;
    logic [31:0] fpu_o = '0;
    logic        fpu_finish = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_o;
    logic [1:0]  res_funct;
    logic        res_err;
`ifdef FPU_ISSUE_STATS_EN
    logic [15:0] stat_issued, stat_timeouts;
`endif

    int cyc = 0;
    int start_cnt = 0;
    int last_start = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    // fpu model configuration, set by the test tasks
    bit          model_en = 1'b1;
    bit          model_fixed = 1'b0;
    int          model_lat = 5;
    logic [31:0] model_fixed_val = '0;
    logic [31:0] op_val = '0;
    int          mcnt = 0;
    bit          pending = 1'b0;

    fpu_issue_ctrl #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_funct  (cmd_funct),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .fpu_funct  (fpu_funct),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_start  (fpu_start),
        .fpu_o      (fpu_o),
        .fpu_finish (fpu_finish),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_o      (res_o),
        .res_funct  (res_funct),
        .res_err    (res_err)
`ifdef FPU_ISSUE_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_timeouts (stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fpu_start) begin
            start_cnt  <= start_cnt + 1;
            last_start <= cyc;
        end
    end

    // fpu model: finish rises model_lat cycles after the start pulse and stays high until the next start
    always @(negedge clk) begin
        if (reset) begin
            fpu_finish <= 1'b0;
            pending    <= 1'b0;
        end else if (fpu_start) begin
            fpu_finish <= 1'b0;
            pending    <= model_en;
            mcnt       <= model_lat;
            op_val     <= model_fixed ? model_fixed_val : (fpu_a ^ fpu_b);
        end else if (pending) begin
            if (mcnt == 1) begin
                fpu_finish <= 1'b1;
                fpu_o      <= op_val;
                pending    <= 1'b0;
            end
            mcnt <= mcnt - 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_cmd(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                            output int acc, output bit ok);
        cmd_funct = f;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        ok        = 1'b0;
        acc       = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (cmd_ready) begin
                acc = cyc;
                ok  = 1'b1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(input int max, output int vcyc, output bit ok);
        ok   = 1'b0;
        vcyc = -1;
        for (int i = 0; i < max && !ok; i++) begin
            if (res_valid) begin
                ok   = 1'b1;
                vcyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total_cnt++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready); else pass_cnt++;
        total_cnt++; if (res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %b want 0", res_valid); else pass_cnt++;
        total_cnt++; if (fpu_start !== 1'b0) $display("[TB] FAIL reset_fpu_start: got %b want 0", fpu_start); else pass_cnt++;
        total_cnt++; if (fpu_funct !== 2'b00) $display("[TB] FAIL reset_fpu_funct: got %b want 00", fpu_funct); else pass_cnt++;
        total_cnt++; if (fpu_a !== 32'h0) $display("[TB] FAIL reset_fpu_a: got %h want 0", fpu_a); else pass_cnt++;
        total_cnt++; if (fpu_b !== 32'h0) $display("[TB] FAIL reset_fpu_b: got %h want 0", fpu_b); else pass_cnt++;
        total_cnt++; if (res_o !== 32'h0) $display("[TB] FAIL reset_res_o: got %h want 0", res_o); else pass_cnt++;
        total_cnt++; if (res_funct !== 2'b00) $display("[TB] FAIL reset_res_funct: got %b want 00", res_funct); else pass_cnt++;
        total_cnt++; if (res_err !== 1'b0) $display("[TB] FAIL reset_res_err: got %b want 0", res_err); else pass_cnt++;
`ifdef FPU_ISSUE_STATS_EN
        total_cnt++; if (stat_issued !== 16'h0) $display("[TB] FAIL reset_stat_issued: got %h want 0", stat_issued); else pass_cnt++;
        total_cnt++; if (stat_timeouts !== 16'h0) $display("[TB] FAIL reset_stat_timeouts: got %h want 0", stat_timeouts); else pass_cnt++;
`endif
    endtask

    task automatic test_single_op;
        int acc, v;
        bit ok;
        model_en = 1'b1; model_lat = 5; model_fixed = 1'b1; model_fixed_val = 32'h40400000;
        send_cmd(2'b01, 32'h3F800000, 32'h40000000, acc, ok);
        total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL single_accept: got %b want 1", ok); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (fpu_start !== 1'b1) $display("[TB] FAIL single_start_pulse: got %b want 1", fpu_start); else pass_cnt++;
        total_cnt++; if (fpu_funct !== 2'b01) $display("[TB] FAIL single_fpu_funct: got %b want 01", fpu_funct); else pass_cnt++;
        total_cnt++; if (fpu_a !== 32'h3F800000) $display("[TB] FAIL single_fpu_a: got %h want 3f800000", fpu_a); else pass_cnt++;
        total_cnt++; if (fpu_b !== 32'h40000000) $display("[TB] FAIL single_fpu_b: got %h want 40000000", fpu_b); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (fpu_start !== 1'b0) $display("[TB] FAIL single_start_width: got %b want 0", fpu_start); else pass_cnt++;
        wait_result(50, v, ok);
        total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL single_res_timeout: got %b want 1", ok); else pass_cnt++;
        total_cnt++; if (last_start !== acc + 2) $display("[TB] FAIL single_start_latency: got %0d want %0d", last_start, acc + 2); else pass_cnt++;
        total_cnt++; if (v !== last_start + 6) $display("[TB] FAIL single_res_latency: got %0d want %0d", v, last_start + 6); else pass_cnt++;
        total_cnt++; if (res_o !== 32'h40400000) $display("[TB] FAIL single_res_o: got %h want 40400000", res_o); else pass_cnt++;
        total_cnt++; if (res_funct !== 2'b01) $display("[TB] FAIL single_res_funct: got %b want 01", res_funct); else pass_cnt++;
        total_cnt++; if (res_err !== 1'b0) $display("[TB] FAIL single_res_err: got %b want 0", res_err); else pass_cnt++;
        handshake();
    endtask

    task automatic test_back_to_back;
        int acc, v;
        bit ok;
        logic [31:0] ea, eb;
        model_en = 1'b1; model_lat = 20; model_fixed = 1'b0;
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ea = 32'hA0000000 + 32'(k);
            eb = 32'h00005500 << k;
            send_cmd(2'(k), ea, eb, acc, ok);
            total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL bp_accept_%0d: got %b want 1", k, ok); else pass_cnt++;
        end
        total_cnt++; if (cmd_ready !== 1'b0) $display("[TB] FAIL bp_full_ready: got %b want 0", cmd_ready); else pass_cnt++;
        cmd_funct = 2'b11; cmd_a = 32'hDEAD0000; cmd_b = 32'h0000BEEF; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++; if (cmd_ready !== 1'b0) $display("[TB] FAIL bp_hold_ready_%0d: got %b want 0", i, cmd_ready); else pass_cnt++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ea = 32'hA0000000 + 32'(k);
            eb = 32'h00005500 << k;
            wait_result(100, v, ok);
            total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL bp_res_wait_%0d: got %b want 1", k, ok); else pass_cnt++;
            total_cnt++; if (res_o !== (ea ^ eb)) $display("[TB] FAIL bp_res_o_%0d: got %h want %h", k, res_o, ea ^ eb); else pass_cnt++;
            total_cnt++; if (res_funct !== 2'(k)) $display("[TB] FAIL bp_res_funct_%0d: got %b want %b", k, res_funct, 2'(k)); else pass_cnt++;
            total_cnt++; if (res_err !== 1'b0) $display("[TB] FAIL bp_res_err_%0d: got %b want 0", k, res_err); else pass_cnt++;
            @(negedge clk);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int acc, v;
        bit ok;
        model_en = 1'b0;
        send_cmd(2'b10, 32'h11111111, 32'h22222222, acc, ok);
        wait_result(120, v, ok);
        total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL tmo_res_wait: got %b want 1", ok); else pass_cnt++;
        total_cnt++; if (v !== last_start + 65) $display("[TB] FAIL tmo_latency: got %0d want %0d", v, last_start + 65); else pass_cnt++;
        total_cnt++; if (res_o !== 32'h7FC00000) $display("[TB] FAIL tmo_res_o: got %h want 7fc00000", res_o); else pass_cnt++;
        total_cnt++; if (res_err !== 1'b1) $display("[TB] FAIL tmo_res_err: got %b want 1", res_err); else pass_cnt++;
        total_cnt++; if (res_funct !== 2'b10) $display("[TB] FAIL tmo_res_funct: got %b want 10", res_funct); else pass_cnt++;
        handshake();
        model_en = 1'b1; model_lat = 3; model_fixed = 1'b0;
        send_cmd(2'b11, 32'h0000F0F0, 32'h0F0F0000, acc, ok);
        wait_result(50, v, ok);
        total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL tmo_next_wait: got %b want 1", ok); else pass_cnt++;
        total_cnt++; if (v !== last_start + 4) $display("[TB] FAIL tmo_next_latency: got %0d want %0d", v, last_start + 4); else pass_cnt++;
        total_cnt++; if (res_o !== 32'h0F0FF0F0) $display("[TB] FAIL tmo_next_res_o: got %h want 0f0ff0f0", res_o); else pass_cnt++;
        total_cnt++; if (res_err !== 1'b0) $display("[TB] FAIL tmo_next_res_err: got %b want 0", res_err); else pass_cnt++;
        handshake();
    endtask

    task automatic test_collision;
        int acc, v;
        bit ok;
        model_en = 1'b1; model_lat = 64; model_fixed = 1'b1; model_fixed_val = 32'h12345678;
        send_cmd(2'b00, 32'h00000001, 32'h00000002, acc, ok);
        wait_result(120, v, ok);
        total_cnt++; if (v !== last_start + 65) $display("[TB] FAIL coll_latency: got %0d want %0d", v, last_start + 65); else pass_cnt++;
        total_cnt++; if (res_err !== 1'b0) $display("[TB] FAIL coll_res_err: got %b want 0", res_err); else pass_cnt++;
        total_cnt++; if (res_o !== 32'h12345678) $display("[TB] FAIL coll_res_o: got %h want 12345678", res_o); else pass_cnt++;
        handshake();
        model_lat = 65; model_fixed_val = 32'h0BADF00D;
        send_cmd(2'b01, 32'h00000003, 32'h00000004, acc, ok);
        wait_result(120, v, ok);
        total_cnt++; if (v !== last_start + 65) $display("[TB] FAIL late_latency: got %0d want %0d", v, last_start + 65); else pass_cnt++;
        total_cnt++; if (res_err !== 1'b1) $display("[TB] FAIL late_res_err: got %b want 1", res_err); else pass_cnt++;
        total_cnt++; if (res_o !== 32'h7FC00000) $display("[TB] FAIL late_res_o: got %h want 7fc00000", res_o); else pass_cnt++;
        handshake();
    endtask

    task automatic test_result_hold;
        int acc, v, s0;
        bit ok;
        model_en = 1'b1; model_lat = 3; model_fixed = 1'b0;
        res_ready = 1'b0;
        send_cmd(2'b01, 32'h000000FF, 32'h0000FF00, acc, ok);
        send_cmd(2'b10, 32'h00FF0000, 32'hFF000000, acc, ok);
        wait_result(50, v, ok);
        total_cnt++; if (res_o !== 32'h0000FFFF) $display("[TB] FAIL hold_first_res_o: got %h want 0000ffff", res_o); else pass_cnt++;
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total_cnt++; if (res_valid !== 1'b1) $display("[TB] FAIL hold_valid_%0d: got %b want 1", i, res_valid); else pass_cnt++;
            total_cnt++; if (res_o !== 32'h0000FFFF) $display("[TB] FAIL hold_res_o_%0d: got %h want 0000ffff", i, res_o); else pass_cnt++;
            total_cnt++; if (fpu_start !== 1'b0) $display("[TB] FAIL hold_no_start_%0d: got %b want 0", i, fpu_start); else pass_cnt++;
        end
        total_cnt++; if (start_cnt !== s0) $display("[TB] FAIL hold_start_count: got %0d want %0d", start_cnt, s0); else pass_cnt++;
        handshake();
        wait_result(50, v, ok);
        total_cnt++; if (res_o !== 32'hFFFF0000) $display("[TB] FAIL hold_second_res_o: got %h want ffff0000", res_o); else pass_cnt++;
        total_cnt++; if (res_funct !== 2'b10) $display("[TB] FAIL hold_second_funct: got %b want 10", res_funct); else pass_cnt++;
        handshake();
    endtask

    task automatic test_reset_midop;
        int acc, s0, seen_valid, seen_start;
        bit ok;
        model_en = 1'b0;
        send_cmd(2'b01, 32'h01010101, 32'h02020202, acc, ok);
        send_cmd(2'b10, 32'h03030303, 32'h04040404, acc, ok);
        send_cmd(2'b11, 32'h05050505, 32'h06060606, acc, ok);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total_cnt++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rmid_cmd_ready: got %b want 1", cmd_ready); else pass_cnt++;
        total_cnt++; if (res_valid !== 1'b0) $display("[TB] FAIL rmid_res_valid: got %b want 0", res_valid); else pass_cnt++;
        total_cnt++; if (fpu_start !== 1'b0) $display("[TB] FAIL rmid_fpu_start: got %b want 0", fpu_start); else pass_cnt++;
        total_cnt++; if (res_err !== 1'b0) $display("[TB] FAIL rmid_res_err: got %b want 0", res_err); else pass_cnt++;
`ifdef FPU_ISSUE_STATS_EN
        total_cnt++; if (stat_issued !== 16'h0) $display("[TB] FAIL rmid_stat_issued: got %h want 0", stat_issued); else pass_cnt++;
        total_cnt++; if (stat_timeouts !== 16'h0) $display("[TB] FAIL rmid_stat_timeouts: got %h want 0", stat_timeouts); else pass_cnt++;
`endif
        model_en = 1'b1; model_lat = 3;
        s0 = start_cnt;
        seen_valid = 0;
        seen_start = 0;
        res_ready = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (res_valid) seen_valid++;
            if (fpu_start) seen_start++;
        end
        res_ready = 1'b0;
        total_cnt++; if (seen_valid !== 0) $display("[TB] FAIL rmid_stale_results: got %0d want 0", seen_valid); else pass_cnt++;
        total_cnt++; if (seen_start !== 0) $display("[TB] FAIL rmid_stale_starts: got %0d want 0", seen_start); else pass_cnt++;
        total_cnt++; if (start_cnt !== s0) $display("[TB] FAIL rmid_start_count: got %0d want %0d", start_cnt, s0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_timeout();
        test_collision();
        test_result_hold();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
